// File: rtl/dmem_mmio_bridge.sv
// Data-side memory for the single-cycle core: word RAM plus MMIO block (CYCLE, TXDATA, STATUS).
// Define DMEM_CYCLE_CMP_EN to add the CMP register and the registered cmp_match flag.
module dmem_mmio_bridge #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        cmp_match
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_CYCLE  = 2'd0,
        REG_TXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CMP    = 2'd3
    } reg_sel_t;

    // Address decode; the byte offset bits [1:0] never take part in selection.
    logic              ram_hit;
    logic              mmio_hit;
    logic [31:0]       mmio_off;
    reg_sel_t          reg_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_byte_bits;

    assign ram_hit          = address_to_mem < RAM_BYTES;
    assign mmio_off         = address_to_mem - MMIO_BASE;
    assign mmio_hit         = (address_to_mem >= MMIO_BASE) && (mmio_off < 32'h10);
    assign reg_sel          = reg_sel_t'(mmio_off[3:2]);
    assign ram_idx          = address_to_mem[RAM_AW+1:2];
    assign unused_byte_bits = ^address_to_mem[1:0];

    logic ram_we;
    logic cycle_we;
    logic push_req;
    logic status_we;

    assign ram_we    = WE && ram_hit;
    assign cycle_we  = WE && mmio_hit && (reg_sel == REG_CYCLE);
    assign push_req  = WE && mmio_hit && (reg_sel == REG_TXDATA);
    assign status_we = WE && mmio_hit && (reg_sel == REG_STATUS);

    // ------------------------------------------------------------------
    // RAM: combinational read, write on the edge (old data seen until then)
    // ------------------------------------------------------------------
    logic [31:0] ram_mem [RAM_WORDS];

    // NOTE: storage arrays carry no reset; contents are only defined once written.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= data_to_mem;
        end
    end

    // ------------------------------------------------------------------
    // CYCLE counter: a write loads the value and suppresses that cycle's increment
    // ------------------------------------------------------------------
    logic [31:0] cycle_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else if (cycle_we) begin
            cycle_q <= data_to_mem;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign pop        = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= data_to_mem[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push_req && !push) begin
                overflow_q <= 1'b1;
            end else if (status_we && data_to_mem[2]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign tx_valid = !fifo_empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;

    logic [31:0] status_word;
    assign status_word = {16'h0000, 8'(count_q), 5'b00000, overflow_q, fifo_full, fifo_empty};

    // ------------------------------------------------------------------
    // Optional cycle compare
    // ------------------------------------------------------------------
`ifdef DMEM_CYCLE_CMP_EN
    logic [31:0] cmp_q;
    logic        cmp_match_q;
    logic        cmp_we;

    assign cmp_we = WE && mmio_hit && (reg_sel == REG_CMP);

    // A CMP write clears the flag even on the edge where a match would set it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q       <= '0;
            cmp_match_q <= 1'b0;
        end else if (cmp_we) begin
            cmp_q       <= data_to_mem;
            cmp_match_q <= 1'b0;
        end else if (cycle_q == cmp_q) begin
            cmp_match_q <= 1'b1;
        end
    end

    assign cmp_match = cmp_match_q;
`else
    assign cmp_match = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        data_from_mem = '0;
        if (ram_hit) begin
            data_from_mem = ram_mem[ram_idx];
        end else if (mmio_hit) begin
            unique case (reg_sel)
                REG_CYCLE:  data_from_mem = cycle_q;
                REG_TXDATA: data_from_mem = '0;
                REG_STATUS: data_from_mem = status_word;
`ifdef DMEM_CYCLE_CMP_EN
                REG_CMP:    data_from_mem = cmp_q;
`else
                REG_CMP:    data_from_mem = '0;
`endif
                default:    data_from_mem = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed self-checking bench for dmem_mmio_bridge (default parameters).
// Honours DMEM_CYCLE_CMP_EN the same way the design does.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_TXDATA = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_CMP    = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        WE = 1'b0;
    logic [31:0] address_to_mem = '0;
    logic [31:0] data_to_mem = '0;
    logic [31:0] data_from_mem;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        cmp_match;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_mmio_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .WE             (WE),
        .address_to_mem (address_to_mem),
        .data_to_mem    (data_to_mem),
        .data_from_mem  (data_from_mem),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .cmp_match      (cmp_match)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        WE             = we;
        address_to_mem = a;
        data_to_mem    = d;
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
        tick();
        bus(1'b0, 32'h0, 32'h0);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus(1'b0, a, 32'h0);
        check(tag, data_from_mem, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus(1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_cmp_match", cmp_match, 0);
        read_chk("rst_status", A_STATUS, 32'h0000_0001);
        read_chk("rst_cycle", A_CYCLE, 32'h0);

        // Counter free-runs from reset
        repeat (5) tick();
        read_chk("cycle_at_5", A_CYCLE, 32'd5);

        // RAM: read-during-write returns the old word, new word next cycle
        write(32'h10, 32'h1111_1111);
        bus(1'b1, 32'h10, 32'hDEAD_BEEF);
        check("ram_rdw_old", data_from_mem, 32'h1111_1111);
        tick();
        read_chk("ram_rd_10", 32'h10, 32'hDEAD_BEEF);
        read_chk("ram_rd_13", 32'h13, 32'hDEAD_BEEF);
        read_chk("unmapped_rd", 32'h4000_0000, 32'h0);
        write(32'h0, 32'hA5A5_A5A5);
        write(32'h3FC, 32'h0BAD_F00D);
        write(32'h400, 32'h1234_5678);
        write(32'h4000_0000, 32'h8765_4321);
        read_chk("ram_rd_0_no_alias", 32'h0, 32'hA5A5_A5A5);
        read_chk("ram_rd_last", 32'h3FF, 32'h0BAD_F00D);
        read_chk("above_ram_rd", 32'h400, 32'h0);

        // Counter load and wrap
        write(A_CYCLE, 32'hFFFF_FFFE);
        read_chk("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
        tick();
        read_chk("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
        tick();
        read_chk("cycle_wrap", A_CYCLE, 32'h0);

        // FIFO ordering with stalled consumer
        tx_ready = 1'b0;
        write(A_TXDATA, 32'h0000_0041);
        check("push1_valid", tx_valid, 1);
        check("push1_data", tx_data, 8'h41);
        write(A_TXDATA, 32'hFFFF_FF42);
        write(A_TXDATA, 32'h0000_0043);
        read_chk("status_3", A_STATUS, 32'h0000_0300);
        read_chk("txdata_reads_0", A_TXDATA, 32'h0);
        tick();
        check("stall_hold", tx_data, 8'h41);
        tx_ready = 1'b1;
        #1;
        check("drain_0", tx_data, 8'h41);
        tick();
        check("drain_1", tx_data, 8'h42);
        tick();
        check("drain_2", tx_data, 8'h43);
        tick();
        check("drained_valid", tx_valid, 0);
        check("drained_data", tx_data, 0);
        read_chk("drained_status", A_STATUS, 32'h0000_0001);

        // Overflow with stalled consumer
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            write(A_TXDATA, 32'h50 + 32'(i));
        end
        read_chk("ovf_status", A_STATUS, 32'h0000_0806);
        write(A_STATUS, 32'h0000_0004);
        read_chk("ovf_cleared", A_STATUS, 32'h0000_0802);

        // Full FIFO: push and pop on the same edge
        bus(1'b1, A_TXDATA, 32'h60);
        tx_ready = 1'b1;
        #1;
        check("full_pp_head", tx_data, 8'h50);
        tick();
        read_chk("full_pp_status", A_STATUS, 32'h0000_0802);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("ovf_drain_%0d", i), tx_data, 8'h50 + 8'(i));
            tick();
        end
        check("ovf_drain_last", tx_data, 8'h60);
        tick();
        check("ovf_drained", tx_valid, 0);

        // Push into empty FIFO while consumer is ready
        write(A_TXDATA, 32'h77);
        check("empty_pp_valid", tx_valid, 1);
        check("empty_pp_data", tx_data, 8'h77);
        read_chk("empty_pp_status", A_STATUS, 32'h0000_0100);
        tick();
        check("empty_pp_popped", tx_valid, 0);

        // Reset mid-operation
        tx_ready = 1'b0;
        write(A_TXDATA, 32'h01);
        write(A_TXDATA, 32'h02);
        write(A_TXDATA, 32'h03);
        write(A_CYCLE, 32'd100);
        read_chk("pre_rst_cycle", A_CYCLE, 32'd100);
        do_reset();
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_data", tx_data, 0);
        read_chk("mid_rst_status", A_STATUS, 32'h0000_0001);
        read_chk("mid_rst_cycle0", A_CYCLE, 32'd0);
        tick();
        read_chk("mid_rst_cycle1", A_CYCLE, 32'd1);

        // Cycle compare
        do_reset();
`ifdef DMEM_CYCLE_CMP_EN
        repeat (3) tick();
        write(A_CMP, 32'd20);
        check("cmp_after_write", cmp_match, 0);
        read_chk("cmp_readback", A_CMP, 32'd20);
        repeat (16) tick();
        read_chk("cmp_cycle20", A_CYCLE, 32'd20);
        check("cmp_before_edge", cmp_match, 0);
        tick();
        check("cmp_rise", cmp_match, 1);
        repeat (4) tick();
        check("cmp_sticky", cmp_match, 1);
        write(A_CMP, 32'd0);
        check("cmp_cleared", cmp_match, 0);
`else
        repeat (3) tick();
        write(A_CMP, 32'd20);
        read_chk("cmp_absent_read", A_CMP, 32'h0);
        repeat (20) tick();
        check("cmp_absent_flag", cmp_match, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
